// File: rtl/matrix_result_collector.sv
// Deserializes the framed 1-bit result stream into NUM_ELEM elements and
// keeps the last good frame in a committed buffer for readout.
module matrix_result_collector #(
   parameter int ELEM_W   = 4,
   parameter int NUM_ELEM = 4,
   parameter int ADDR_W   = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              z_in,
   input  logic              clear,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [ELEM_W-1:0] rd_data,
   output logic              busy,
   output logic              frame_valid,
   output logic              frame_err,
   output logic              have_result,
   output logic [7:0]        frame_cnt
);

   localparam int BW = (ELEM_W > 1) ? $clog2(ELEM_W) : 1;
   localparam int EW = $clog2(NUM_ELEM);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_STOP
   } state_t;

   state_t            state_q, state_d;
   logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
   logic [EW-1:0]     elem_cnt_q, elem_cnt_d;
   logic [ELEM_W-1:0] work_q [NUM_ELEM];
   logic [ELEM_W-1:0] work_d [NUM_ELEM];
   logic [ELEM_W-1:0] comm_q [NUM_ELEM];
   logic [ELEM_W-1:0] comm_d [NUM_ELEM];
   logic              fv_q, fv_d;
   logic              fe_q, fe_d;
   logic              have_q, have_d;
   logic [7:0]        cnt_q, cnt_d;

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      elem_cnt_d = elem_cnt_q;
      work_d     = work_q;
      comm_d     = comm_q;
      fv_d       = 1'b0;
      fe_d       = 1'b0;
      have_d     = have_q;
      cnt_d      = cnt_q;

      unique case (state_q)
         S_IDLE: begin
            if (z_in) begin
               state_d    = S_DATA;
               bit_cnt_d  = '0;
               elem_cnt_d = '0;
            end
         end
         S_DATA: begin
            // MSB-first: shift left, new bit enters at the LSB
            for (int i = 0; i < NUM_ELEM; i++) begin
               if (elem_cnt_q == EW'(i)) begin
                  work_d[i] = ELEM_W'({work_q[i], z_in});
               end
            end
            if (bit_cnt_q == BW'(ELEM_W - 1)) begin
               bit_cnt_d = '0;
               if (elem_cnt_q == EW'(NUM_ELEM - 1)) begin
                  state_d = S_STOP;
               end else begin
                  elem_cnt_d = elem_cnt_q + EW'(1);
               end
            end else begin
               bit_cnt_d = bit_cnt_q + BW'(1);
            end
         end
         S_STOP: begin
            // a 1 in the stop slot is an error, never a new start bit
            state_d = S_IDLE;
            if (!z_in) begin
               comm_d = work_q;
               fv_d   = 1'b1;
               have_d = 1'b1;
               cnt_d  = cnt_q + 8'd1;
            end else begin
               fe_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (clear) begin
         state_d = S_IDLE;
         for (int i = 0; i < NUM_ELEM; i++) begin
            work_d[i] = '0;
            comm_d[i] = '0;
         end
         fv_d   = 1'b0;
         fe_d   = 1'b0;
         have_d = 1'b0;
         cnt_d  = cnt_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         bit_cnt_q  <= '0;
         elem_cnt_q <= '0;
         for (int i = 0; i < NUM_ELEM; i++) begin
            work_q[i] <= '0;
            comm_q[i] <= '0;
         end
         fv_q   <= 1'b0;
         fe_q   <= 1'b0;
         have_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         elem_cnt_q <= elem_cnt_d;
         work_q     <= work_d;
         comm_q     <= comm_d;
         fv_q       <= fv_d;
         fe_q       <= fe_d;
         have_q     <= have_d;
         cnt_q      <= cnt_d;
      end
   end

   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NUM_ELEM; i++) begin
         if (rd_addr == ADDR_W'(i)) begin
            rd_data = comm_q[i];
         end
      end
   end

   assign busy        = (state_q != S_IDLE);
   assign frame_valid = fv_q;
   assign frame_err   = fe_q;
   assign have_result = have_q;
   assign frame_cnt   = cnt_q;

endmodule

// File: tb/tb_matrix_result_collector.sv
// Scoreboard bench: frames are issued with their expected outcome queued,
// a negedge monitor pops and checks on every frame_valid/frame_err pulse.
`timescale 1ns/100ps
module tb_matrix_result_collector;

   logic       clk = 1'b0;
   logic       rst;
   logic       z_in;
   logic       clear;
   logic [1:0] rd_addr;
   logic [3:0] rd_data;
   logic       busy;
   logic       fv;
   logic       fe;
   logic       have;
   logic [7:0] fcnt;

   matrix_result_collector #(
      .ELEM_W(4),
      .NUM_ELEM(4),
      .ADDR_W(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .z_in(z_in),
      .clear(clear),
      .rd_addr(rd_addr),
      .rd_data(rd_data),
      .busy(busy),
      .frame_valid(fv),
      .frame_err(fe),
      .have_result(have),
      .frame_cnt(fcnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic        err;
      logic [15:0] data;
      logic [7:0]  cnt;
      logic        have;
      int          cyc;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int failures = 0;

   // reference state: committed frame (element 0 in the top nibble)
   logic [15:0] m_comm;
   logic        m_have;
   int          m_cnt;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic read_all(output logic [15:0] v);
      for (int a = 0; a < 4; a++) begin
         rd_addr = 2'(a);
         #0.2;
         v[15-4*a -: 4] = rd_data;
      end
   endtask

   task automatic check_idle(input string tag, input logic [7:0] ecnt);
      logic [15:0] v;
      read_all(v);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_have"}, 32'(have), 32'd0);
      chk({tag, "_cnt"}, 32'(fcnt), 32'(ecnt));
      chk({tag, "_rd"}, 32'(v), 32'd0);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         z_in = 1'b0;
         clear = 1'b0;
      end
   endtask

   task automatic send_frame(input logic [15:0] data, input logic stop,
                             input int clr_at);
      logic [17:0] fb;
      exp_t e;
      fb = {1'b1, data, stop};
      for (int i = 0; i < 18; i++) begin
         @(posedge clk);
         #1;
         z_in = fb[17-i];
         clear = (i == clr_at);
         if (i == clr_at) begin
            @(posedge clk);
            #1;
            clear = 1'b0;
            z_in = 1'b0;
            m_comm = '0;
            m_have = 1'b0;
            check_idle("clear", 8'(m_cnt));
            return;
         end
         if (i == 1) chk("busy_in_frame", 32'(busy), 32'd1);
         if (i == 17) begin
            if (!stop) begin
               m_comm = data;
               m_have = 1'b1;
               m_cnt++;
            end
            e.err = stop;
            e.data = m_comm;
            e.cnt = 8'(m_cnt);
            e.have = m_have;
            e.cyc = cyc + 1;
            q.push_back(e);
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      z_in = 1'b0;
      clear = 1'b0;
      #1;
      m_comm = '0;
      m_have = 1'b0;
      m_cnt = 0;
      check_idle("reset", 8'd0);
      chk("reset_fv", 32'(fv), 32'd0);
      chk("reset_fe", 32'(fe), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin : monitor
      logic [15:0] v;
      exp_t e;
      forever begin
         @(negedge clk);
         if (fv || fe) begin
            chk("fv_fe_exclusive", 32'(fv && fe), 32'd0);
            if (q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_pulse: valid=%0b err=%0b none pending",
                        fv, fe);
            end else begin
               e = q.pop_front();
               read_all(v);
               chk("pulse_err", 32'(fe), 32'(e.err));
               chk("pulse_valid", 32'(fv), 32'(!e.err));
               chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
               chk("frame_cnt", 32'(fcnt), 32'(e.cnt));
               chk("have_result", 32'(have), 32'(e.have));
               chk("rd_data", 32'(v), 32'(e.data));
            end
         end
      end
   end

   initial begin : driver
      int gap;
      int clr;
      logic st;
      rst = 1'b1;
      z_in = 1'b0;
      clear = 1'b0;
      rd_addr = '0;
      m_comm = '0;
      m_have = 1'b0;
      m_cnt = 0;
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // reset in the middle of a frame, with a good frame already held
      send_frame(16'h3A0F, 1'b0, -1);
      idle(2);
      @(posedge clk);
      #1;
      z_in = 1'b1;
      repeat (5) begin
         @(posedge clk);
         #1;
         z_in = 1'($urandom);
      end
      do_reset();

      send_frame(16'h3A0F, 1'b0, -1);
      idle(1);

      send_frame(16'hFFFF, 1'b1, -1);
      idle(1);
      chk("no_false_start", 32'(busy), 32'd0);
      idle(1);

      send_frame(16'h1234, 1'b0, -1);
      send_frame(16'h5678, 1'b0, -1);
      idle(2);

      send_frame(16'h9ABC, 1'b0, 7);
      idle(1);
      send_frame(16'h4321, 1'b0, -1);
      send_frame(16'h8765, 1'b0, 17);
      idle(2);

      repeat (150) begin
         st = ($urandom_range(0, 4) == 0);
         clr = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 17)) : -1;
         send_frame(16'($urandom), st, clr);
         gap = int'($urandom_range(0, 2));
         idle(gap);
      end
      idle(3);

      @(posedge clk);
      #1;
      do_reset();
      repeat (256) begin
         send_frame(16'($urandom), 1'b0, -1);
         idle(int'($urandom_range(0, 1)));
      end
      idle(2);
      chk("wrap_cnt", 32'(fcnt), 32'd0);
      chk("wrap_have", 32'(have), 32'd1);

      for (int k = 0; k < 20 && q.size() != 0; k++) @(posedge clk);
      chk("queue_drained", 32'(q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
